// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
package cordic_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned SN_W     = 4;
    localparam int unsigned ID_W_MAX = 3;

    localparam logic [DATA_W-1:0] X_INIT_DEF  = 16'h2000;
    localparam logic [DATA_W-1:0] Y_INIT_DEF  = 16'h0000;
    localparam logic [SN_W-1:0]   SN_INIT_DEF = 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [DATA_W-1:0]   cosh;
        logic [DATA_W-1:0]   sinh;
    } res_t;

endpackage

// File: rtl/cordic_res_fifo.sv
// Result FIFO with occupancy count and show-ahead read of the head entry.
module cordic_res_fifo
    import cordic_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_en,
    input  res_t wr_data,
    input  logic rd_en,
    output res_t rd_data,
    output logic empty,
    output logic full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    res_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap at DEPTH so non power-of-two depths also work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(wr_en && full));

endmodule

// File: rtl/cordic_req_sched.sv
// Round-robin scheduler sharing one pipelined hyperbolic CORDIC datapath between requesters.
// Define CORDIC_SCHED_STATS_EN to add per-requester grant and credit-stall counters.
module cordic_req_sched
    import cordic_pkg::*;
#(
    parameter int unsigned       NUM_REQ   = 4,
    parameter int unsigned       PIPE_LAT  = 10,
    parameter int unsigned       RES_DEPTH = 16,
    parameter logic [DATA_W-1:0] X_INIT    = X_INIT_DEF,
    parameter logic [DATA_W-1:0] Y_INIT    = Y_INIT_DEF,
    parameter logic [SN_W-1:0]   SN_INIT   = SN_INIT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [DATA_W*NUM_REQ-1:0]   req_theta,
    input  logic                        flush,
    output logic [DATA_W-1:0]           pipe_x,
    output logic [DATA_W-1:0]           pipe_y,
    output logic [DATA_W-1:0]           pipe_theta,
    output logic [SN_W-1:0]             pipe_sn,
    input  logic [DATA_W-1:0]           pipe_xo,
    input  logic [DATA_W-1:0]           pipe_yo,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [$clog2(NUM_REQ)-1:0]  res_id,
    output logic [DATA_W-1:0]           res_cosh,
    output logic [DATA_W-1:0]           res_sinh,
    output logic                        busy,
    output logic                        drained
`ifdef CORDIC_SCHED_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]       stat_grants,
    output logic [15:0]                 stat_stalls
`endif
);

    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned CRED_W = $clog2(RES_DEPTH + 1);

    sched_state_t      state;
    logic [ID_W-1:0]   rr_ptr;
    logic [CRED_W-1:0] credits;
    logic [PIPE_LAT-1:0] tag_v;
    logic [ID_W-1:0]   tag_id [PIPE_LAT];

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    int unsigned       arb_idx;
    logic              issue;
    logic              pop;
    logic              in_flight;
    logic              fifo_empty;
    logic              fifo_full;
    res_t              fifo_wdata;
    res_t              fifo_rdata;

    assign pipe_x  = X_INIT;
    assign pipe_y  = Y_INIT;
    assign pipe_sn = SN_INIT;

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        arb_idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            arb_idx = 32'(rr_ptr) + i;
            if (arb_idx >= NUM_REQ) begin
                arb_idx = arb_idx - NUM_REQ;
            end
            if (!gnt_found && req_valid[arb_idx]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(arb_idx);
            end
        end
    end

    assign issue      = (state == RUN) && (credits != '0) && gnt_found;
    assign req_ready  = issue ? (NUM_REQ'(1) << gnt_id) : '0;
    assign pipe_theta = issue ? req_theta[DATA_W*32'(gnt_id) +: DATA_W] : '0;

    assign in_flight = |tag_v;
    assign res_valid = !fifo_empty;
    assign pop       = res_valid && res_ready;
    assign busy      = in_flight || !fifo_empty;
    assign drained   = (state == DRAIN) && !in_flight && fifo_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (|req_valid && !flush) state <= RUN;
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end else if (!(|req_valid) && !in_flight && fifo_empty) begin
                        state <= IDLE;
                    end
                end
                DRAIN:   if (!flush && drained) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Credits cover in-flight tags plus buffered results, so the FIFO can never overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr  <= '0;
            credits <= CRED_W'(RES_DEPTH);
        end else begin
            if (issue) begin
                rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (issue && !pop) begin
                credits <= credits - 1'b1;
            end else if (pop && !issue) begin
                credits <= credits + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v     <= {tag_v[PIPE_LAT-2:0], issue};
            tag_id[0] <= gnt_id;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign fifo_wdata.id   = ID_W_MAX'(tag_id[PIPE_LAT-1]);
    assign fifo_wdata.cosh = pipe_xo;
    assign fifo_wdata.sinh = pipe_yo;

    cordic_res_fifo #(
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tag_v[PIPE_LAT-1]),
        .wr_data (fifo_wdata),
        .rd_en   (res_ready),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign res_id   = ID_W'(fifo_rdata.id);
    assign res_cosh = fifo_rdata.cosh;
    assign res_sinh = fifo_rdata.sinh;

`ifdef CORDIC_SCHED_STATS_EN
    logic [15:0] grant_cnt [NUM_REQ];
    logic [15:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                grant_cnt[k] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (issue && (gnt_id == ID_W'(k)) && (grant_cnt[k] != 16'hFFFF)) begin
                    grant_cnt[k] <= grant_cnt[k] + 1'b1;
                end
            end
            if ((state == RUN) && |req_valid && (credits == '0) && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
        assign stat_grants[16*k +: 16] = grant_cnt[k];
    end
    assign stat_stalls = stall_cnt;
`endif

endmodule

// File: tb/tb_cordic_req_sched.sv
// Directed bench for cordic_req_sched with a behavioural 10-stage datapath stand-in.
module tb_cordic_req_sched;
    import cordic_pkg::*;

    localparam int NR = 4;
    localparam int PL = 10;
    localparam int RD = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [16*NR-1:0]  req_theta;
    logic              flush;
    logic [15:0]       pipe_x, pipe_y, pipe_theta;
    logic [3:0]        pipe_sn;
    logic [15:0]       pipe_xo, pipe_yo;
    logic              res_valid, res_ready;
    logic [1:0]        res_id;
    logic [15:0]       res_cosh, res_sinh;
    logic              busy, drained;
`ifdef CORDIC_SCHED_STATS_EN
    logic [16*NR-1:0]  stat_grants;
    logic [15:0]       stat_stalls;
`endif

    always #5 clk = ~clk;

    cordic_req_sched #(
        .NUM_REQ   (NR),
        .PIPE_LAT  (PL),
        .RES_DEPTH (RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_theta  (req_theta),
        .flush      (flush),
        .pipe_x     (pipe_x),
        .pipe_y     (pipe_y),
        .pipe_theta (pipe_theta),
        .pipe_sn    (pipe_sn),
        .pipe_xo    (pipe_xo),
        .pipe_yo    (pipe_yo),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_cosh   (res_cosh),
        .res_sinh   (res_sinh),
        .busy       (busy),
        .drained    (drained)
`ifdef CORDIC_SCHED_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stalls(stat_stalls)
`endif
    );

    // Stand-in datapath: cosh = theta + x, sinh = theta ^ 16'h5A5A, PL clocks of latency.
    logic [15:0] dx [PL];
    logic [15:0] dy [PL];
    always @(posedge clk) begin
        dx[0] <= pipe_theta + pipe_x;
        dy[0] <= pipe_theta ^ 16'h5A5A;
        for (int i = 1; i < PL; i++) begin
            dx[i] <= dx[i-1];
            dy[i] <= dy[i-1];
        end
    end
    assign pipe_xo = dx[PL-1];
    assign pipe_yo = dy[PL-1];

    typedef struct { int cyc; int id; logic [15:0] theta; } gnt_t;
    typedef struct { int cyc; int id; logic [15:0] cosh; logic [15:0] sinh; } rs_t;

    gnt_t gq[$];
    rs_t  rq[$];
    int   cyc;
    int   total = 0;
    int   bad = 0;

    // Advance one clock, logging handshakes seen just before the active edge.
    task automatic tick();
        gnt_t g;
        rs_t  r;
        #1;
        if (!reset && (req_ready & req_valid) != '0) begin
            g.cyc = cyc;
            g.id = -1;
            for (int k = 0; k < NR; k++) if (req_ready[k]) g.id = k;
            g.theta = pipe_theta;
            gq.push_back(g);
        end
        if (res_valid && res_ready) begin
            r.cyc = cyc;
            r.id = int'(res_id);
            r.cosh = res_cosh;
            r.sinh = res_sinh;
            rq.push_back(r);
        end
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        req_theta = '0;
        flush = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        gq.delete();
        rq.delete();
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        req_theta = '0;
        flush = 1'b0;
        res_ready = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b want=0000", req_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b want=0", res_valid); end
        total++; if (busy !== 1'b0 || drained !== 1'b0) begin bad++; $display("FAIL rst_busy_drained got=%b%b want=00", busy, drained); end
        total++; if (pipe_x !== 16'h2000 || pipe_y !== 16'h0000 || pipe_sn !== 4'd0) begin bad++; $display("FAIL rst_seeds got=%h/%h/%h want=2000/0000/0", pipe_x, pipe_y, pipe_sn); end
        total++; if (pipe_theta !== 16'h0000) begin bad++; $display("FAIL rst_theta got=%h want=0000", pipe_theta); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        req_valid = 4'hF;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_no_grant got=%b want=0000", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single();
        int n;
        do_reset();
        res_ready = 1'b1;
        req_theta[47:32] = 16'h1000;
        req_valid = 4'b0100;
        n = 0; while (gq.size() < 1 && n < 10) begin tick(); n++; end
        req_valid = '0;
        n = 0; while (rq.size() < 1 && n < 30) begin tick(); n++; end
        repeat (5) tick();
        total++; if (gq.size() != 1) begin bad++; $display("FAIL single_grants got=%0d want=1", gq.size()); end
        total++; if (rq.size() != 1) begin bad++; $display("FAIL single_results got=%0d want=1", rq.size()); end
        if (gq.size() >= 1 && rq.size() >= 1) begin
            total++; if (gq[0].id != 2) begin bad++; $display("FAIL single_gnt_id got=%0d want=2", gq[0].id); end
            total++; if (rq[0].id != 2) begin bad++; $display("FAIL single_res_id got=%0d want=2", rq[0].id); end
            total++; if (rq[0].cosh !== 16'h3000 || rq[0].sinh !== 16'h4A5A) begin bad++; $display("FAIL single_data got=%h/%h want=3000/4a5a", rq[0].cosh, rq[0].sinh); end
            total++; if (rq[0].cyc - gq[0].cyc != PL + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", rq[0].cyc - gq[0].cyc, PL + 1); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [15:0] th;
        do_reset();
        res_ready = 1'b1;
        for (int k = 0; k < NR; k++) req_theta[16*k +: 16] = 16'(16'h1111 * (k + 1));
        req_valid = 4'hF;
        n = 0; while (gq.size() < 8 && n < 20) begin tick(); n++; end
        req_valid = '0;
        n = 0; while ((rq.size() < 8 || busy) && n < 40) begin tick(); n++; end
        total++; if (gq.size() != 8 || rq.size() != 8) begin bad++; $display("FAIL rr_counts got=%0d/%0d want=8/8", gq.size(), rq.size()); end
        for (int i = 0; i < 8 && i < gq.size() && i < rq.size(); i++) begin
            th = 16'(16'h1111 * ((i % NR) + 1));
            total++; if (gq[i].id != i % NR || gq[i].theta !== th) begin bad++; $display("FAIL rr_grant[%0d] got=%0d/%h want=%0d/%h", i, gq[i].id, gq[i].theta, i % NR, th); end
            total++; if (rq[i].id != i % NR || rq[i].cosh !== th + 16'h2000 || rq[i].sinh !== (th ^ 16'h5A5A)) begin bad++; $display("FAIL rr_result[%0d] got=%0d/%h/%h want=%0d/%h/%h", i, rq[i].id, rq[i].cosh, rq[i].sinh, i % NR, th + 16'h2000, th ^ 16'h5A5A); end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        res_ready = 1'b0;
        req_valid = 4'b0001;
        for (int t = 0; t < 40; t++) begin
            req_theta[15:0] = 16'(16'h1000 + gq.size());
            tick();
        end
        total++; if (gq.size() != RD) begin bad++; $display("FAIL bp_grants got=%0d want=%0d", gq.size(), RD); end
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_blocked got=%b want=0000", req_ready); end
        total++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_cosh !== 16'h3000) begin bad++; $display("FAIL bp_head_hold got=%b/%0d/%h want=1/0/3000", res_valid, res_id, res_cosh); end
`ifdef CORDIC_SCHED_STATS_EN
        total++; if (stat_stalls !== 16'd23) begin bad++; $display("FAIL stat_stalls got=%0d want=23", stat_stalls); end
        total++; if (stat_grants[15:0] !== 16'd16) begin bad++; $display("FAIL stat_grants0 got=%0d want=16", stat_grants[15:0]); end
`endif
        res_ready = 1'b1;
        n = 0;
        while (gq.size() < 20 && n < 60) begin
            req_theta[15:0] = 16'(16'h1000 + gq.size());
            tick();
            n++;
        end
        req_valid = '0;
        n = 0; while ((rq.size() < 20 || busy) && n < 60) begin tick(); n++; end
        total++; if (gq.size() != 20 || rq.size() != 20) begin bad++; $display("FAIL bp_counts got=%0d/%0d want=20/20", gq.size(), rq.size()); end
        for (int i = 0; i < 20 && i < rq.size() && i < gq.size(); i++) begin
            total++;
            if (gq[i].theta !== 16'(16'h1000 + i) || rq[i].id != 0 ||
                rq[i].cosh !== 16'(16'h3000 + i) || rq[i].sinh !== (16'(16'h1000 + i) ^ 16'h5A5A)) begin
                bad++;
                $display("FAIL bp_result[%0d] got=%h/%0d/%h/%h want=%h/0/%h/%h", i, gq[i].theta, rq[i].id, rq[i].cosh, rq[i].sinh,
                         16'(16'h1000 + i), 16'(16'h3000 + i), 16'(16'h1000 + i) ^ 16'h5A5A);
            end
        end
    endtask

    task automatic test_flush();
        int n;
        do_reset();
        res_ready = 1'b1;
        req_theta[15:0] = 16'h0011;
        req_theta[31:16] = 16'h0022;
        req_valid = 4'b0011;
        n = 0; while (gq.size() < 5 && n < 20) begin tick(); n++; end
        req_valid = '0;
        flush = 1'b1;
        tick();
        req_valid = 4'b0011;
        repeat (30) tick();
        total++; if (gq.size() != 5 || rq.size() != 5) begin bad++; $display("FAIL flush_counts got=%0d/%0d want=5/5", gq.size(), rq.size()); end
        for (int i = 0; i < 5 && i < rq.size(); i++) begin
            total++; if (rq[i].id != i % 2 || rq[i].cosh !== ((i % 2) ? 16'h2022 : 16'h2011)) begin bad++; $display("FAIL flush_result[%0d] got=%0d/%h want=%0d/%h", i, rq[i].id, rq[i].cosh, i % 2, (i % 2) ? 16'h2022 : 16'h2011); end
        end
        total++; if (drained !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL flush_drained got=%b/%b/%b want=1/0/0000", drained, busy, req_ready); end
        flush = 1'b0;
        req_valid = '0;
        tick();
        total++; if (drained !== 1'b0) begin bad++; $display("FAIL flush_exit got=%b want=0", drained); end
        req_valid = 4'b0011;
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL flush_idle got=%b want=0000", req_ready); end
        tick();
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL flush_resume got=%b want=0010", req_ready); end
        tick();
        req_valid = '0;
        repeat (20) tick();
    endtask

    task automatic test_reset_midop();
        int n;
        do_reset();
        res_ready = 1'b0;
        req_theta[15:0] = 16'h0777;
        req_valid = 4'b0001;
        n = 0; while (gq.size() < 9 && n < 20) begin tick(); n++; end
        req_valid = '0;
        repeat (4) tick();
        total++; if (res_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL midop_pre got=%b/%b want=1/1", res_valid, busy); end
        reset = 1'b1;
        #1;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midop_async got=%b/%b want=0/0", res_valid, busy); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        res_ready = 1'b1;
        repeat (20) tick();
        total++; if (rq.size() != 3 - 3 || res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midop_stale got=%0d/%b/%b want=0/0/0", rq.size(), res_valid, busy); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_theta = '0;
        flush = 1'b0;
        res_ready = 1'b0;
        cyc = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
